// File: rtl/sr_bank_pkg.sv
// Shared op encodings and FSM state type for the SR-controlled bit bank arbiter.
package sr_bank_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_RST  = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/sr2t_bit.sv
// One storage bit: a T flip-flop fed through SR-to-T conversion, active only when en=1.
module sr2t_bit
  import sr_bank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q
);

  logic q_r;
  logic t_s;

  // SR-to-T conversion; S and R together is the invalid op and holds the bit
  always_comb begin
    t_s = 1'b0;
    if (en && ({r, s} != OP_INV)) begin
      t_s = (s & ~q_r) | (r & q_r);
    end else begin
      t_s = 1'b0;
    end
  end

  // T flip-flop state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= 1'b0;
    end else begin
      q_r <= q_r ^ t_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter sharing a bank of N SR-controlled bits between two requesters;
// a 3-state FSM latches a command, applies it, then pulses done for one cycle.
module sr_bank_arbiter
  import sr_bank_pkg::*;
#(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [1:0]      req0_op,
  input  logic [IDXW-1:0] req0_idx,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [1:0]      req1_op,
  input  logic [IDXW-1:0] req1_idx,
  output logic            req1_ready,
  output logic [N-1:0]    q,
  output logic            done,
  output logic            done_src,
  output logic            done_changed,
  output logic            done_err
);

  state_t          state_r, state_s;
  logic            rr_ptr_r;
  logic [1:0]      op_r;
  logic [IDXW-1:0] idx_r;
  logic            src_r;
  logic            win_s;
  logic            any_s;
  logic [N-1:0]    en_s;
  logic [N-1:0]    q_s;
  logic            cur_bit_s;
  logic            in_range_s;
  logic            changed_s;
  logic            done_r, done_src_r, done_changed_r, done_err_r;

  assign any_s = req0_valid | req1_valid;
  // A lone requester always wins; rr_ptr only breaks ties
  assign win_s = (req0_valid && req1_valid) ? rr_ptr_r : req1_valid;

  // Next-state and combinational grant
  always_comb begin
    state_s    = state_r;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          state_s    = ST_APPLY;
          req0_ready = ~win_s;
          req1_ready = win_s;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_APPLY: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Command latch and round-robin pointer update on grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= OP_HOLD;
      idx_r    <= {IDXW{1'b0}};
      src_r    <= 1'b0;
      rr_ptr_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && any_s) begin
      op_r     <= win_s ? req1_op  : req0_op;
      idx_r    <= win_s ? req1_idx : req0_idx;
      src_r    <= win_s;
      rr_ptr_r <= ~win_s;
    end
  end

  // Bit select and one-hot enable decode of the latched index
  always_comb begin
    in_range_s = (32'(idx_r) < 32'(N));
    cur_bit_s  = 1'b0;
    en_s       = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      cur_bit_s = (idx_r == IDXW'(i)) ? q_s[i] : cur_bit_s;
      en_s[i]   = (state_r == ST_APPLY) && (idx_r == IDXW'(i));
    end
    changed_s = in_range_s && (op_r != OP_INV) &&
                ((op_r[0] & ~cur_bit_s) | (op_r[1] & cur_bit_s));
  end

  for (genvar g = 0; g < N; g++) begin : g_bit
    sr2t_bit u_bit (
      .clk (clk),
      .rst (rst),
      .en  (en_s[g]),
      .s   (op_r[0]),
      .r   (op_r[1]),
      .q   (q_s[g])
    );
  end

  // Completion flags registered at the end of APPLY so they are valid only in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r         <= 1'b0;
      done_src_r     <= 1'b0;
      done_changed_r <= 1'b0;
      done_err_r     <= 1'b0;
    end else if (state_r == ST_APPLY) begin
      done_r         <= 1'b1;
      done_src_r     <= src_r;
      done_changed_r <= changed_s;
      done_err_r     <= ~in_range_s;
    end else begin
      done_r         <= 1'b0;
      done_src_r     <= 1'b0;
      done_changed_r <= 1'b0;
      done_err_r     <= 1'b0;
    end
  end

  assign q            = q_s;
  assign done         = done_r;
  assign done_src     = done_src_r;
  assign done_changed = done_changed_r;
  assign done_err     = done_err_r;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Scoreboard bench: a bit-array reference model predicts grants and completion results,
// and a separate monitor compares every done pulse against the queued expectation.
module tb_sr_bank_arbiter;

  localparam int NB = 6;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          v0, v1;
  logic [1:0]    op0, op1;
  logic [IW-1:0] idx0, idx1;
  logic          rdy0, rdy1;
  logic [NB-1:0] q;
  logic          done, done_src, done_changed, done_err;

  typedef struct {
    bit            src;
    bit            changed;
    bit            err;
    logic [NB-1:0] qv;
  } exp_t;

  exp_t sbq[$];
  int   grants[$];
  bit   mq[NB];
  int   m_rr, m_wait;
  bit   acc0, acc1;
  int   errors = 0;
  int   checks = 0;

  sr_bank_arbiter #(.N(NB), .IDXW(IW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_op(op0), .req0_idx(idx0), .req0_ready(rdy0),
    .req1_valid(v1), .req1_op(op1), .req1_idx(idx1), .req1_ready(rdy1),
    .q(q), .done(done), .done_src(done_src),
    .done_changed(done_changed), .done_err(done_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] model_q();
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = mq[i];
    return v;
  endfunction

  // Reference behaviour of one accepted command, from the op/index rules
  task automatic model_accept(input int w, input logic [1:0] op, input logic [IW-1:0] idx);
    exp_t e;
    int   ix;
    bit   in_range, cur;
    ix       = int'(idx);
    in_range = ix < NB;
    cur      = in_range ? mq[ix] : 1'b0;
    e.src     = (w == 1);
    e.err     = !in_range;
    e.changed = in_range && ((op == 2'b01 && !cur) || (op == 2'b10 && cur));
    if (e.changed) mq[ix] = !cur;
    e.qv = model_q();
    sbq.push_back(e);
  endtask

  // One clock: predict and check grants at the negedge, then return just after the posedge
  task automatic step();
    int w;
    @(negedge clk);
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst) begin
      if (m_wait > 0) begin
        m_wait--;
      end else if (v0 || v1) begin
        w = (v0 && v1) ? m_rr : (v1 ? 1 : 0);
        if (w == 0) begin
          acc0 = 1'b1;
          model_accept(0, op0, idx0);
        end else begin
          acc1 = 1'b1;
          model_accept(1, op1, idx1);
        end
        m_rr   = 1 - w;
        m_wait = 2;
      end
      check("ready0", rdy0, acc0);
      check("ready1", rdy1, acc1);
      if (rdy0) grants.push_back(0);
      if (rdy1) grants.push_back(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic [1:0] op, input logic [IW-1:0] idx);
    bit got;
    got = 1'b0;
    if (k == 0) begin v0 = 1'b1; op0 = op; idx0 = idx; end
    else        begin v1 = 1'b1; op1 = op; idx1 = idx; end
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      got = (k == 0) ? acc0 : acc1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no grant expected grant to req%0d", k);
    end
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (3) step();
  endtask

  task automatic drive_random();
    if (acc0 || !v0) begin
      if ($urandom_range(0, 2) != 0) begin
        v0 = 1'b1; op0 = 2'($urandom_range(0, 3)); idx0 = IW'($urandom_range(0, 7));
      end else begin
        v0 = 1'b0;
      end
    end
    if (acc1 || !v1) begin
      if ($urandom_range(0, 2) != 0) begin
        v1 = 1'b1; op1 = 2'($urandom_range(0, 3)); idx1 = IW'($urandom_range(0, 7));
      end else begin
        v1 = 1'b0;
      end
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected none pending");
          end else begin
            e = sbq.pop_front();
            check("done_src", done_src, e.src);
            check("done_changed", done_changed, e.changed);
            check("done_err", done_err, e.err);
            check("q_at_done", q, e.qv);
          end
        end else begin
          check("flags_idle", {done_src, done_changed, done_err}, 32'd0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0;
    op0 = 2'b00; op1 = 2'b00; idx0 = 3'd0; idx1 = 3'd0;
    m_rr = 0; m_wait = 0;
    for (int i = 0; i < NB; i++) mq[i] = 1'b0;
    #23;
    check("reset_q", q, 32'd0);
    check("reset_done", {done, done_src, done_changed, done_err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(0, 2'b01, 3'd3);
    check("q_set3", q, 32'h08);
    issue(1, 2'b01, 3'd3);
    check("q_set3_again", q, 32'h08);
    issue(1, 2'b10, 3'd3);
    check("q_rst3", q, 32'h00);
    issue(0, 2'b01, 3'd5);
    check("q_set5", q, 32'h20);
    issue(0, 2'b11, 3'd5);
    check("q_inv5", q, 32'h20);
    issue(1, 2'b10, 3'd5);
    check("q_rst5", q, 32'h00);
    issue(0, 2'b01, 3'd7);
    check("q_oor7", q, 32'h00);
    issue(1, 2'b10, 3'd6);
    check("q_oor6", q, 32'h00);

    // Both requesters valid continuously: grants must alternate
    grants.delete();
    v0 = 1'b1; op0 = 2'b01; idx0 = 3'd0;
    v1 = 1'b1; op1 = 2'b01; idx1 = 3'd1;
    repeat (12) step();
    v0 = 1'b0; v1 = 1'b0;
    repeat (3) step();
    check("grant_count", grants.size(), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("grant_order", grants[i], i % 2);
    check("q_both", q, 32'h03);

    // Reset while a command sits in APPLY
    v0 = 1'b1; op0 = 2'b01; idx0 = 3'd2;
    for (int n = 0; n < 20 && !acc0; n++) step();
    check("rst_test_accept", acc0, 1'b1);
    v0 = 1'b0;
    rst = 1'b1;
    sbq.delete();
    for (int i = 0; i < NB; i++) mq[i] = 1'b0;
    m_rr = 0;
    m_wait = 0;
    #1;
    check("q_async_reset", q, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    grants.delete();
    v0 = 1'b1; op0 = 2'b01; idx0 = 3'd4;
    v1 = 1'b1; op1 = 2'b01; idx1 = 3'd2;
    step();
    check("grant_after_reset", rdy0, 1'b0);
    check("grant_after_reset_req0", acc0 && grants.size() == 1 && grants[0] == 0, 1'b1);
    v0 = 1'b0; v1 = 1'b0;
    repeat (3) step();
    check("q_after_reset_cmd", q, 32'h10);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      drive_random();
      step();
    end
    v0 = 1'b0; v1 = 1'b0;
    repeat (4) step();
    check("final_q", q, model_q());
    check("scoreboard_empty", sbq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
